// File: rtl/loader_pkg.sv
// loader_pkg: shared definitions for the asset loader slice.
//   bpw_of()          bytes per download word for a given word width
//   region_bits_of()  width of a region index for a given region count
//   GW_REGION_STARTS  Game & Watch layout: header 0x0, image 0x80,
//                     mask 0x17BB80, ROM 0x187250 (entry i = region i)
//   region_t          region index for the default four-region layout
package loader_pkg;

  function automatic int bpw_of(input int data_width);
    return data_width / 8;
  endfunction

  function automatic int region_bits_of(input int region_count);
    return (region_count > 1) ? $clog2(region_count) : 1;
  endfunction

  localparam int GW_ADDR_WIDTH   = 25;
  localparam int GW_REGION_COUNT = 4;

  localparam logic [GW_REGION_COUNT*GW_ADDR_WIDTH-1:0] GW_REGION_STARTS =
    {25'h187250, 25'h17BB80, 25'h80, 25'h0};

  typedef logic [region_bits_of(GW_REGION_COUNT)-1:0] region_t;

  localparam region_t REGION_HEADER = '0;

endpackage

// File: rtl/asset_loader_if.sv
// asset_loader_if: host download bus plus the serialised payload byte stream.
//   master: host/consumer side (drives ioctl_*, out_ready)
//   slave : loader side (drives ioctl_wait, out_valid/data/addr/region)
interface asset_loader_if #(
  parameter int DATA_WIDTH   = 16,
  parameter int ADDR_WIDTH   = 25,
  parameter int REGION_COUNT = 4
);
  localparam int BPW    = loader_pkg::bpw_of(DATA_WIDTH);
  localparam int OUT_AW = ADDR_WIDTH + $clog2(BPW);
  localparam int RB     = loader_pkg::region_bits_of(REGION_COUNT);

  logic                  ioctl_download;
  logic                  ioctl_wr;
  logic [ADDR_WIDTH-1:0] ioctl_addr;
  logic [DATA_WIDTH-1:0] ioctl_dout;
  logic                  ioctl_wait;

  logic                  out_valid;
  logic                  out_ready;
  logic [7:0]            out_data;
  logic [OUT_AW-1:0]     out_addr;
  logic [RB-1:0]         out_region;

  modport master (
    output ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout, out_ready,
    input  ioctl_wait, out_valid, out_data, out_addr, out_region
  );

  modport slave (
    input  ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout, out_ready,
    output ioctl_wait, out_valid, out_data, out_addr, out_region
  );

endinterface

// File: rtl/word_serializer.sv
// word_serializer: latches one download word and walks its bytes out,
// lowest byte first.
//   flush        download-start pulse; aborts the word in flight
//   load/load_*  word strobe with its decoded region and word offset
//   busy         EMIT state (registered), used directly as ioctl_wait
//   byte_*       current byte, its region-relative byte address and region
//   hdr_we       header byte write strobe (one per cycle, no handshake)
//   out_valid/ready  payload byte handshake
module word_serializer #(
  parameter int DATA_WIDTH  = 16,
  parameter int ADDR_WIDTH  = 25,
  parameter int REGION_BITS = 2,
  parameter int OUT_AW      = 26
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   flush,
  input  logic                   load,
  input  logic [DATA_WIDTH-1:0]  load_word,
  input  logic [REGION_BITS-1:0] load_region,
  input  logic [ADDR_WIDTH-1:0]  load_offset,
  output logic                   busy,
  output logic [7:0]             byte_data,
  output logic [OUT_AW-1:0]      byte_addr,
  output logic [REGION_BITS-1:0] byte_region,
  output logic                   hdr_we,
  output logic                   out_valid,
  input  logic                   out_ready
);

  localparam int BPW   = DATA_WIDTH / 8;
  localparam int IDX_W = (BPW > 1) ? $clog2(BPW) : 1;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_EMIT = 1'b1;

  logic [0:0]             state;
  logic [DATA_WIDTH-1:0]  word_q;
  logic [REGION_BITS-1:0] region_q;
  logic [ADDR_WIDTH-1:0]  off_q;
  logic [IDX_W-1:0]       idx;
  logic                   emit, is_hdr, step, last;

  assign emit      = (state == S_EMIT);
  assign is_hdr    = (region_q == '0);
  assign busy      = emit;
  assign out_valid = emit && !is_hdr;
  assign hdr_we    = emit && is_hdr;
  // header bytes advance every cycle; payload bytes only on handshake
  assign step      = hdr_we || (out_valid && out_ready);
  assign last      = (idx == IDX_W'(BPW - 1));

  assign byte_region = region_q;
  // widen before multiplying so no offset bits are lost
  assign byte_addr   = OUT_AW'(off_q) * OUT_AW'(BPW) + OUT_AW'(idx);

  always_comb begin
    byte_data = '0;
    for (int b = 0; b < BPW; b++)
      if (idx == IDX_W'(b)) byte_data = word_q[8*b +: 8];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= S_IDLE;
      word_q   <= '0;
      region_q <= '0;
      off_q    <= '0;
      idx      <= '0;
    end else if (load && (flush || state == S_IDLE)) begin
      // a strobe on the download-start edge is taken after the flush
      state    <= S_EMIT;
      word_q   <= load_word;
      region_q <= load_region;
      off_q    <= load_offset;
      idx      <= '0;
    end else if (flush) begin
      state <= S_IDLE;
    end else if (step) begin
      if (last) state <= S_IDLE;
      else      idx   <= idx + IDX_W'(1);
    end
  end

endmodule

// File: rtl/asset_loader.sv
// asset_loader: splits the host download word stream into a header region
// and payload regions. Payload words become a byte stream with valid/ready
// and region-relative byte addresses; header bytes land in header_image.
//   clk, reset_n    clock, async active-low reset
//   bus (slave)     ioctl_* download bus, ioctl_wait, payload byte stream
//   header_image    captured header, byte k at [8k+7:8k]
//   header_valid    all header bytes captured with a good version
//   version_error   header byte 0 mismatched EXPECTED_VERSION (sticky)
//   overrun         strobe seen while ioctl_wait was high (sticky)
module asset_loader
  import loader_pkg::*;
#(
  parameter int DATA_WIDTH   = 16,
  parameter int ADDR_WIDTH   = GW_ADDR_WIDTH,
  parameter int REGION_COUNT = GW_REGION_COUNT,
  parameter logic [REGION_COUNT*ADDR_WIDTH-1:0] REGION_STARTS = GW_REGION_STARTS,
  parameter int HEADER_BYTES = 48,
  parameter logic [7:0] EXPECTED_VERSION = 8'h01
) (
  input  logic                      clk,
  input  logic                      reset_n,
  asset_loader_if.slave             bus,
  output logic [HEADER_BYTES*8-1:0] header_image,
  output logic                      header_valid,
  output logic                      version_error,
  output logic                      overrun
);

  localparam int BPW = bpw_of(DATA_WIDTH);
  localparam int RB  = region_bits_of(REGION_COUNT);
  localparam int OAW = ADDR_WIDTH + $clog2(BPW);

  // download-start edge
  logic dl_q, start;
  assign start = bus.ioctl_download && !dl_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) dl_q <= 1'b0;
    else          dl_q <= bus.ioctl_download;
  end

  // region decode: highest region whose start is <= address
  logic [RB-1:0]         dec_region;
  logic [ADDR_WIDTH-1:0] dec_base, dec_offset;

  always_comb begin
    dec_region = '0;
    dec_base   = '0;
    for (int i = 0; i < REGION_COUNT; i++) begin
      if (bus.ioctl_addr >= REGION_STARTS[i*ADDR_WIDTH +: ADDR_WIDTH]) begin
        dec_region = RB'(i);
        dec_base   = REGION_STARTS[i*ADDR_WIDTH +: ADDR_WIDTH];
      end
    end
  end

  assign dec_offset = bus.ioctl_addr - dec_base;

  logic           busy, hdr_we;
  logic [7:0]     byte_data;
  logic [OAW-1:0] byte_addr;
  logic [RB-1:0]  byte_region;

  word_serializer #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .REGION_BITS(RB),
    .OUT_AW     (OAW)
  ) u_ser (
    .clk        (clk),
    .reset_n    (reset_n),
    .flush      (start),
    .load       (bus.ioctl_wr),
    .load_word  (bus.ioctl_dout),
    .load_region(dec_region),
    .load_offset(dec_offset),
    .busy       (busy),
    .byte_data  (byte_data),
    .byte_addr  (byte_addr),
    .byte_region(byte_region),
    .hdr_we     (hdr_we),
    .out_valid  (bus.out_valid),
    .out_ready  (bus.out_ready)
  );

  assign bus.ioctl_wait = busy;
  assign bus.out_data   = byte_data;
  assign bus.out_addr   = byte_addr;
  assign bus.out_region = byte_region;

  // header checks; the same-cycle version result gates header_valid
  logic ver_bad, ver_err_nxt, hdr_last;
  assign ver_bad     = hdr_we && (byte_addr == '0) && (byte_data != EXPECTED_VERSION);
  assign ver_err_nxt = version_error || ver_bad;
  assign hdr_last    = hdr_we && (byte_addr == OAW'(HEADER_BYTES - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      header_image  <= '0;
      header_valid  <= 1'b0;
      version_error <= 1'b0;
      overrun       <= 1'b0;
    end else if (start) begin
      header_image  <= '0;
      header_valid  <= 1'b0;
      version_error <= 1'b0;
      overrun       <= 1'b0;
    end else begin
      if (bus.ioctl_wr && busy) overrun <= 1'b1;
      if (ver_bad)              version_error <= 1'b1;
      if (hdr_last && !ver_err_nxt) header_valid <= 1'b1;
      // bytes past HEADER_BYTES match no slot and are dropped
      if (hdr_we) begin
        for (int k = 0; k < HEADER_BYTES; k++)
          if (byte_addr == OAW'(k)) header_image[8*k +: 8] <= byte_data;
      end
    end
  end

endmodule

// File: tb/tb_asset_loader.sv
// tb_asset_loader: directed bench for asset_loader, 16-bit default layout
// plus a 32-bit word instance.
module tb_asset_loader;
  import loader_pkg::*;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  logic seen_valid;

  asset_loader_if #(.DATA_WIDTH(16)) if16();
  asset_loader_if #(.DATA_WIDTH(32)) if32();

  logic [383:0] img16, img32;
  logic hv16, ve16, ov16, hv32, ve32, ov32;

  asset_loader #(.DATA_WIDTH(16)) u_dut16 (
    .clk(clk), .reset_n(reset_n), .bus(if16),
    .header_image(img16), .header_valid(hv16),
    .version_error(ve16), .overrun(ov16)
  );

  asset_loader #(.DATA_WIDTH(32)) u_dut32 (
    .clk(clk), .reset_n(reset_n), .bus(if32),
    .header_image(img32), .header_valid(hv32),
    .version_error(ve32), .overrun(ov32)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // strobe one word into the 16-bit DUT and wait (bounded) for ioctl_wait to drop
  task automatic send16(input logic [24:0] a, input logic [15:0] d);
    if16.ioctl_addr = a;
    if16.ioctl_dout = d;
    if16.ioctl_wr   = 1'b1;
    @(negedge clk);
    if16.ioctl_wr   = 1'b0;
    for (int c = 0; c < 16 && if16.ioctl_wait; c++) begin
      seen_valid = seen_valid | if16.out_valid;
      @(negedge clk);
    end
    chk("wait_release", 64'(if16.ioctl_wait), 64'd0);
  endtask

  task automatic send_header(input logic [7:0] ver);
    send16(25'd0, {8'h01, ver});
    for (int k = 1; k < 24; k++) begin
      if (k == 23) chk("hv_before_last", 64'(hv16), 64'd0);
      send16(25'(k), {8'(2*k + 1), 8'(2*k)});
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    if16.ioctl_download = 0; if16.ioctl_wr = 0; if16.ioctl_addr = '0;
    if16.ioctl_dout = '0;    if16.out_ready = 0;
    if32.ioctl_download = 0; if32.ioctl_wr = 0; if32.ioctl_addr = '0;
    if32.ioctl_dout = '0;    if32.out_ready = 0;
    seen_valid = 1'b0;
    repeat (2) @(negedge clk);

    // reset state
    chk("rst_wait",  64'(if16.ioctl_wait), 64'd0);
    chk("rst_valid", 64'(if16.out_valid),  64'd0);
    chk("rst_flags", {61'd0, hv16, ve16, ov16}, 64'd0);
    chk("rst_image", 64'(|img16), 64'd0);
    reset_n = 1'b1;
    @(negedge clk);

    // 32-bit word into the image region
    if32.out_ready  = 1'b1;
    if32.ioctl_addr = 25'h80;
    if32.ioctl_dout = 32'h44332211;
    if32.ioctl_wr   = 1'b1;
    @(negedge clk);
    if32.ioctl_wr = 1'b0;
    for (int b = 0; b < 4; b++) begin
      chk("w32_valid",  64'(if32.out_valid),  64'd1);
      chk("w32_data",   64'(if32.out_data),   64'(8'h11 * (b + 1)));
      chk("w32_addr",   64'(if32.out_addr),   64'(b));
      chk("w32_region", 64'(if32.out_region), 64'd1);
      @(negedge clk);
    end
    chk("w32_done", {62'd0, if32.out_valid, if32.ioctl_wait}, 64'd0);

    // good header, first strobe on the download-start edge
    if16.out_ready = 1'b1;
    if16.ioctl_download = 1'b1;
    seen_valid = 1'b0;
    send_header(8'h01);
    chk("hdr_valid",   64'(hv16), 64'd1);
    chk("hdr_ver_err", 64'(ve16), 64'd0);
    chk("hdr_no_out",  64'(seen_valid), 64'd0);
    chk("hdr_b0",      64'(img16[7:0]),     64'h01);
    chk("hdr_b1",      64'(img16[15:8]),    64'h01);
    chk("hdr_b20",     64'(img16[167:160]), 64'h14);
    chk("hdr_b47",     64'(img16[383:376]), 64'h2F);

    // new download clears; bad version header
    if16.ioctl_download = 1'b0;
    @(negedge clk);
    if16.ioctl_download = 1'b1;
    @(negedge clk);
    chk("clr_hv",  64'(hv16), 64'd0);
    chk("clr_img", 64'(|img16), 64'd0);
    send_header(8'h02);
    chk("bad_ver_err", 64'(ve16), 64'd1);
    chk("bad_hv",      64'(hv16), 64'd0);
    chk("bad_b0",      64'(img16[7:0]), 64'h02);
    if16.ioctl_download = 1'b0;
    @(negedge clk);
    if16.ioctl_download = 1'b1;
    @(negedge clk);
    chk("clr2_ver", 64'(ve16), 64'd0);
    chk("clr2_hv",  64'(hv16), 64'd0);

    // mask-region word 0x17BB81 = BEEF
    if16.ioctl_addr = 25'h17BB81;
    if16.ioctl_dout = 16'hBEEF;
    if16.ioctl_wr   = 1'b1;
    @(negedge clk);
    if16.ioctl_wr = 1'b0;
    chk("beef_valid0", 64'(if16.out_valid),  64'd1);
    chk("beef_wait0",  64'(if16.ioctl_wait), 64'd1);
    chk("beef_data0",  64'(if16.out_data),   64'hEF);
    chk("beef_addr0",  64'(if16.out_addr),   64'd2);
    chk("beef_reg0",   64'(if16.out_region), 64'd2);
    @(negedge clk);
    chk("beef_data1",  64'(if16.out_data),   64'hBE);
    chk("beef_addr1",  64'(if16.out_addr),   64'd3);
    @(negedge clk);
    chk("beef_done", {62'd0, if16.out_valid, if16.ioctl_wait}, 64'd0);

    // ROM-region word under back-pressure
    if16.out_ready  = 1'b0;
    if16.ioctl_addr = 25'h187255;
    if16.ioctl_dout = 16'h5AA5;
    if16.ioctl_wr   = 1'b1;
    @(negedge clk);
    if16.ioctl_wr = 1'b0;
    for (int s = 0; s < 5; s++) begin
      chk("stall_data", 64'(if16.out_data),   64'hA5);
      chk("stall_addr", 64'(if16.out_addr),   64'd10);
      chk("stall_wait", 64'(if16.ioctl_wait), 64'd1);
      @(negedge clk);
    end
    chk("stall_reg",   64'(if16.out_region), 64'd3);
    chk("stall_held",  64'(if16.out_data),   64'hA5);
    if16.out_ready = 1'b1;
    @(negedge clk);
    chk("stall_data1", 64'(if16.out_data),  64'h5A);
    chk("stall_addr1", 64'(if16.out_addr),  64'd11);
    chk("stall_vld1",  64'(if16.out_valid), 64'd1);
    @(negedge clk);
    chk("stall_done", {62'd0, if16.out_valid, if16.ioctl_wait}, 64'd0);

    // overrun: second strobe during EMIT is dropped
    if16.ioctl_addr = 25'h82;
    if16.ioctl_dout = 16'h3412;
    if16.ioctl_wr   = 1'b1;
    @(negedge clk);
    chk("ovr_data0", 64'(if16.out_data), 64'h12);
    chk("ovr_addr0", 64'(if16.out_addr), 64'd4);
    chk("ovr_flag0", 64'(ov16), 64'd0);
    if16.ioctl_addr = 25'h83;
    if16.ioctl_dout = 16'hFFFF;
    @(negedge clk);
    if16.ioctl_wr = 1'b0;
    chk("ovr_flag",  64'(ov16), 64'd1);
    chk("ovr_data1", 64'(if16.out_data), 64'h34);
    chk("ovr_addr1", 64'(if16.out_addr), 64'd5);
    @(negedge clk);
    chk("ovr_done", {62'd0, if16.out_valid, if16.ioctl_wait}, 64'd0);
    chk("ovr_sticky", 64'(ov16), 64'd1);

    // reset mid-word
    if16.ioctl_addr = 25'h80;
    if16.ioctl_dout = 16'h7788;
    if16.ioctl_wr   = 1'b1;
    @(negedge clk);
    if16.ioctl_wr = 1'b0;
    chk("rstm_valid_pre", 64'(if16.out_valid), 64'd1);
    reset_n = 1'b0;
    #1;
    chk("rstm_drop", {62'd0, if16.out_valid, if16.ioctl_wait}, 64'd0);
    chk("rstm_ovr",  64'(ov16), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("rstm_idle", {62'd0, if16.out_valid, if16.ioctl_wait}, 64'd0);
    if16.ioctl_wr = 1'b1;
    @(negedge clk);
    if16.ioctl_wr = 1'b0;
    chk("rstm_data", 64'(if16.out_data), 64'h88);
    chk("rstm_addr", 64'(if16.out_addr), 64'd0);
    @(negedge clk);
    chk("rstm_data1", 64'(if16.out_data), 64'h77);
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
